gyj_uart_rx_core: RTL and testbench
===================================

Name: gyj_uart_rx_core

Overview:
- Receive engine of the UART: 16x-oversampled deserializer for the io_port_rxd line.
- Recovers 8-bit frames (start, 8 data LSB-first, optional parity, stop) and checks parity and framing.
- Holds each byte in a one-entry buffer for the register block; the register block exposes it through DATA_REG and sets CSR bit 4 (rx done).
- Sits between the rxd pad and the ICB register/CSR logic of the UART top.

Parameters:
- DIV_W, 16, width of the oversample divisor (CSR[31:16]).
- OS_RATE, 16, oversample ticks per bit (fixed; a power of two).

Ports:
- clk  in  1  block clock (16 MHz or 144 MHz system clock).
- rst_n  in  1  asynchronous active-low reset.
- i_baud_div  in  DIV_W  tick period minus 1. One tick every i_baud_div+1 clocks (0x8 = 115200 bps @16 MHz; 0x4d = 115200 bps @144 MHz).
- i_rx_en  in  1  AND of UART_EN, RX_EN and BAUD_EN from CTRL.
- i_parity_en  in  1  parity bit present (NOT NO_PARITY).
- i_parity_even  in  1  1 = even parity, 0 = odd parity.
- i_rxd  in  1  raw asynchronous serial input.
- o_rx_data  out  8  received byte.
- o_rx_valid  out  1  holding register full.
- i_rx_ready  in  1  consumer takes the byte (DATA_REG read).
- o_parity_err  out  1  parity error flag for the byte in o_rx_data.
- o_frame_err  out  1  stop bit sampled 0 for the byte in o_rx_data.
- o_overrun  out  1  sticky: a byte was dropped because the holding register was full.
- i_ovr_clr  in  1  clears o_overrun.

Behaviour:
- Reset values: all outputs 0; synchronizer flops 1; FSM IDLE; counters 0.
- Synchronizer: i_rxd passes through 2 flops (rxd_s). Falling-edge detect compares rxd_s with its previous value.
- Tick generator: div_cnt counts 0..i_baud_div; tick fires when div_cnt == i_baud_div, then div_cnt reloads 0. div_cnt is held at 0 in IDLE. A change of i_baud_div mid-frame takes effect on the next compare.
- os_cnt: 0..15, advances on each tick, wraps 15→0 at bit boundaries.
- Sampling: rxd_s is sampled on the ticks where os_cnt = 7, 8, 9. The bit value is the majority of the three samples and is resolved on the tick where os_cnt = 9.
- FSM:
  - IDLE: when i_rx_en=1 and a falling edge is seen → START, div_cnt=0, os_cnt=0.
  - START: if the voted value is 1 → IDLE (false start, no output). Otherwise → DATA at os_cnt 15 wrap, bit_idx=0.
  - DATA: shifts the voted bit into shift[bit_idx] (LSB first). After bit_idx=7 → PARITY if i_parity_en, else STOP.
  - PARITY: stores the voted bit p. par_err = (^shift ^ p) != (i_parity_even ? 0 : 1). Then → STOP.
  - STOP: on the os_cnt=9 vote tick (mid-bit, early return so the next start edge is not missed) → IDLE and raise a one-cycle complete pulse; frame_err = ~vote.
- Completion, registered, so o_rx_valid rises 1 clock after the STOP vote tick:
  - o_rx_valid=0, or o_rx_valid=1 with i_rx_ready=1 in the same cycle: load o_rx_data, o_parity_err (0 when parity is disabled) and o_frame_err; o_rx_valid=1; no overrun.
  - o_rx_valid=1 with i_rx_ready=0: new byte discarded; o_overrun set; buffer unchanged.
- Handshake: i_rx_ready with o_rx_valid=1 clears o_rx_valid next cycle. Data and error flags hold their values. i_rx_ready with o_rx_valid=0 is ignored.
- o_overrun: cleared by i_ovr_clr. If set and clear happen in the same cycle, set wins.
- i_rx_en low at any time: FSM → IDLE and counters cleared on the next clock. The holding register and flags are untouched.
- rst_n asserted mid-frame: everything returns to reset values asynchronously. After release, the line must be seen idle (1) before a falling edge counts.
- Line held low after a frame: no new frame starts until a 1→0 edge is seen.

Decomposition:
- Shared package/include (uart_define.v): OS_RATE, FSM state encodings (IDLE, START, DATA, PARITY, STOP), CSR bit positions (RX_DONE = bit 4, DIV field [31:16]) and CTRL field positions.
- One sub-module: gyj_uart_baud_tick (div_cnt plus tick generation, with clear input). It is reusable by the TX core.

Test Plan:
- 16 MHz, i_baud_div=0x8, parity even. Drive 0xA5 (parity bit 0), 144 clk per bit → o_rx_data=0xA5, o_rx_valid=1 one clock after mid-stop, o_parity_err=0, o_frame_err=0.
- Same setup, drive 0x3C with parity bit 1 → o_rx_data=0x3C, o_parity_err=1. Repeat with i_parity_even=0 → o_parity_err=0.
- i_parity_en=0, drive 0x00 with stop bit 0 → o_frame_err=1. Then drive 0xFF with a correct frame → 0xFF, o_frame_err=0.
- Low glitch of 40 clocks on i_rxd → FSM back to IDLE, o_rx_valid stays 0. Then 0x5A back-to-back at 144 MHz, i_baud_div=0x4d → 0x5A received.
- Send 0x11 then 0x22 with i_rx_ready=0 → o_rx_data=0x11, o_overrun=1. Assert i_rx_ready and i_ovr_clr → o_rx_valid=0, o_overrun=0.
- Assert rst_n low during DATA bit 3 of 0x77 → all outputs 0. Release, send 0x77 → 0x77 received cleanly. Separately, drop i_rx_en mid-frame → no byte is produced.

Source files
------------

// File: rtl/gyj_uart_rx_core_pkg.sv
// gyj_uart_rx_core_pkg: shared UART constants, receiver FSM states and holding-register layout
package gyj_uart_rx_core_pkg;
  localparam int OS_RATE = 16;
  localparam int OS_W    = $clog2(OS_RATE);
  localparam logic [OS_W-1:0] OS_SAMP0 = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0] OS_SAMP1 = OS_W'(OS_RATE / 2);
  localparam logic [OS_W-1:0] OS_VOTE  = OS_W'(OS_RATE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OS_RATE - 1);
  localparam int CSR_RX_DONE      = 4;
  localparam int CSR_DIV_LSB      = 16;
  localparam int CSR_DIV_MSB      = 31;
  localparam int CTRL_UART_EN     = 0;
  localparam int CTRL_TX_EN       = 1;
  localparam int CTRL_RX_EN       = 2;
  localparam int CTRL_BAUD_EN     = 3;
  localparam int CTRL_NO_PARITY   = 4;
  localparam int CTRL_PARITY_EVEN = 5;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;
  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_buf_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/gyj_uart_baud_tick.sv
// gyj_uart_baud_tick: oversample tick generator, one tick every i_div+1 clocks, held at 0 while cleared
module gyj_uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  // >= keeps a mid-frame divisor shrink from running the counter the long way round
  always_comb begin
    o_tick    = !i_clr && (div_cnt_q >= i_div);
    div_cnt_d = (i_clr || o_tick) ? '0 : div_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end
endmodule

// File: rtl/gyj_uart_rx_core.sv
// gyj_uart_rx_core: 16x-oversampled UART receiver with majority vote, parity/framing checks and one-byte holding register
module gyj_uart_rx_core
  import gyj_uart_rx_core_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_rx_en,
  input  logic             i_parity_en,
  input  logic             i_parity_even,
  input  logic             i_rxd,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun,
  input  logic             i_ovr_clr
);
  logic            sync1_q, sync1_d, rxd_s_q, rxd_s_d, rxd_prev_q, rxd_prev_d;
  logic            armed_q, armed_d;
  logic [1:0]      vld_q, vld_d, samp_q, samp_d;
  rx_state_e       state_q, state_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  rx_buf_t         buf_q, buf_d;
  logic            rx_valid_q, rx_valid_d, ovr_q, ovr_d;
  logic            tick, idle, fall, vote, at_vote, at_wrap, done, take, perr;

  gyj_uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (idle),
    .i_div  (i_baud_div),
    .o_tick (tick)
  );

  // armed only once the synchronizer holds a real line sample of 1, so a line low at reset release is not a start
  always_comb begin
    sync1_d    = i_rxd;
    rxd_s_d    = sync1_q;
    rxd_prev_d = rxd_s_q;
    vld_d      = {vld_q[0], 1'b1};
    armed_d    = armed_q | (vld_q[1] & rxd_s_q);
    idle       = (state_q == ST_IDLE) || !i_rx_en;
    fall       = armed_q & rxd_prev_q & ~rxd_s_q;
    vote       = maj3(samp_q[1], samp_q[0], rxd_s_q);
    at_vote    = tick && (os_cnt_q == OS_VOTE);
    at_wrap    = tick && (os_cnt_q == OS_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (!i_rx_en) state_d = ST_IDLE;
    else
      unique case (state_q)
        ST_IDLE:   state_d = fall ? ST_START : ST_IDLE;
        ST_START:  state_d = (at_vote && vote) ? ST_IDLE : at_wrap ? ST_DATA : ST_START;
        ST_DATA:   state_d = (at_wrap && bit_idx_q == 3'd7) ? (i_parity_en ? ST_PARITY : ST_STOP) : ST_DATA;
        ST_PARITY: state_d = at_wrap ? ST_STOP : ST_PARITY;
        ST_STOP:   state_d = at_vote ? ST_IDLE : ST_STOP;
        default:   state_d = ST_IDLE;
      endcase
  end

  // stop is resolved mid-bit so the next start edge is seen even when frames are back to back
  always_comb begin
    os_cnt_d   = idle ? '0 : tick ? os_cnt_q + 1'b1 : os_cnt_q;
    samp_d     = (tick && (os_cnt_q == OS_SAMP0 || os_cnt_q == OS_SAMP1)) ? {samp_q[0], rxd_s_q} : samp_q;
    bit_idx_d  = (state_q == ST_START) ? 3'd0 : (state_q == ST_DATA && at_wrap) ? bit_idx_q + 1'b1 : bit_idx_q;
    shift_d    = (state_q == ST_DATA && at_vote) ? {vote, shift_q[7:1]} : shift_q;
    par_d      = (state_q == ST_PARITY && at_vote) ? vote : par_q;
    done       = (state_q == ST_STOP) && at_vote;
    take       = !rx_valid_q || i_rx_ready;
    perr       = i_parity_en & (^{shift_q, par_q, ~i_parity_even});
    buf_d      = (done && take) ? '{data: shift_q, perr: perr, ferr: ~vote} : buf_q;
    rx_valid_d = done ? (take | rx_valid_q) : (rx_valid_q & ~i_rx_ready);
    ovr_d      = (done && !take) ? 1'b1 : i_ovr_clr ? 1'b0 : ovr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      vld_q      <= '0;
      armed_q    <= 1'b0;
      samp_q     <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      buf_q      <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rxd_s_q    <= rxd_s_d;
      rxd_prev_q <= rxd_prev_d;
      vld_q      <= vld_d;
      armed_q    <= armed_d;
      samp_q     <= samp_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      buf_q      <= buf_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_rx_data    = buf_q.data;
  assign o_parity_err = buf_q.perr;
  assign o_frame_err  = buf_q.ferr;
  assign o_rx_valid   = rx_valid_q;
  assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_gyj_uart_rx_core.sv
// tb_gyj_uart_rx_core: scenario tasks driving serial frames, checked against a byte-level receiver model
module tb_gyj_uart_rx_core;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] i_baud_div = 16'd8;
  logic        i_rx_en = 1'b1, i_parity_en = 1'b1, i_parity_even = 1'b1, i_rxd = 1'b1;
  logic        i_rx_ready = 1'b0, i_ovr_clr = 1'b0;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid, o_parity_err, o_frame_err, o_overrun;
  int          checks = 0, passed = 0, cyc = 0, rise_cyc = -1, frame_start = 0, bitlen = 144;
  logic        v_prev = 1'b0;
  logic        m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic [11:0] obs;

  gyj_uart_rx_core #(.DIV_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_baud_div    (i_baud_div),
    .i_rx_en       (i_rx_en),
    .i_parity_en   (i_parity_en),
    .i_parity_even (i_parity_even),
    .i_rxd         (i_rxd),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .i_rx_ready    (i_rx_ready),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun),
    .i_ovr_clr     (i_ovr_clr)
  );

  always #5 clk = ~clk;
  assign obs = {o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_overrun};

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_rx_valid && !v_prev) rise_cyc = cyc;
    v_prev = o_rx_valid;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [11:0] expv();
    return {m_valid, m_data, m_perr, m_ferr, m_ovr};
  endfunction

  task automatic set_div(input logic [15:0] v);
    i_baud_div = v;
    bitlen = 16 * (int'(v) + 1);
  endtask

  task automatic drive_bit(input logic b);
    i_rxd = b;
    repeat (bitlen) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (i_parity_en) drive_bit(p);
    drive_bit(stop);
    i_rxd = 1'b1;
  endtask

  // byte-level view: parity judged by counting ones, buffer is either free (load) or full (drop + overrun)
  task automatic frame(input logic [7:0] d, input logic p, input logic stop, input logic rdy);
    int   ones;
    logic perr;
    send_frame(d, p, stop);
    ones = $countones(d) + int'(p);
    perr = i_parity_en && ((ones % 2) != (i_parity_even ? 0 : 1));
    if (!m_valid || rdy) begin
      m_data  = d;
      m_perr  = perr;
      m_ferr  = !stop;
      m_valid = !rdy;
    end else m_ovr = 1'b1;
  endtask

  task automatic read_byte(input logic clr);
    i_rx_ready = 1'b1;
    i_ovr_clr  = clr;
    @(negedge clk);
    i_rx_ready = 1'b0;
    i_ovr_clr  = 1'b0;
    m_valid    = 1'b0;
    if (clr) m_ovr = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (obs !== 12'h000) $display("FAIL reset_hold: got %h expected %h", obs, 12'h000); else passed++;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (obs !== expv()) $display("FAIL reset_release: got %h expected %h", obs, expv()); else passed++;
  endtask

  task automatic test_parity();
    int mid;
    set_div(16'h8); i_parity_en = 1'b1; i_parity_even = 1'b1;
    rise_cyc = -1;
    frame(8'hA5, 1'b0, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL a5_even: got %h expected %h", obs, expv()); else passed++;
    mid = frame_start + 10 * bitlen + bitlen / 2;
    checks++; if (rise_cyc < mid || rise_cyc > mid + bitlen / 4) $display("FAIL valid_timing: got cycle %0d expected %0d..%0d", rise_cyc, mid, mid + bitlen / 4); else passed++;
    read_byte(1'b0);
    checks++; if (obs !== expv()) $display("FAIL a5_read: got %h expected %h", obs, expv()); else passed++;
    frame(8'h3C, 1'b1, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL 3c_even: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
    i_parity_even = 1'b0;
    frame(8'h3C, 1'b1, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL 3c_odd: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
  endtask

  task automatic test_frame_err();
    i_parity_en = 1'b0;
    frame(8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL frame_err_00: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
    frame(8'hFF, 1'b0, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL frame_ok_ff: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
  endtask

  task automatic test_glitch_fast();
    set_div(16'h4d); i_parity_en = 1'b1; i_parity_even = 1'b1;
    i_rxd = 1'b0;
    repeat (40) @(negedge clk);
    i_rxd = 1'b1;
    repeat (1200) @(negedge clk);
    checks++; if (obs !== expv()) $display("FAIL glitch: got %h expected %h", obs, expv()); else passed++;
    frame(8'h5A, 1'b0, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL fast_5a: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    set_div(16'h8); i_parity_en = 1'b0;
    d1 = 8'($urandom); d2 = 8'($urandom);
    i_rx_ready = 1'b1;
    frame(d1, 1'b0, 1'b1, 1'b1);
    checks++; if (obs !== expv()) $display("FAIL b2b_first: got %h expected %h", obs, expv()); else passed++;
    frame(d2, 1'b0, 1'b1, 1'b1);
    checks++; if (obs !== expv()) $display("FAIL b2b_second: got %h expected %h", obs, expv()); else passed++;
    i_rx_ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overrun();
    i_parity_en = 1'b0;
    frame(8'h11, 1'b0, 1'b1, 1'b0);
    frame(8'h22, 1'b0, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL overrun_set: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b1);
    checks++; if (obs !== expv()) $display("FAIL overrun_clr: got %h expected %h", obs, expv()); else passed++;
  endtask

  task automatic test_rx_en_drop();
    i_parity_en = 1'b0;
    fork
      send_frame(8'h96, 1'b0, 1'b1);
      begin
        repeat (4 * bitlen) @(negedge clk);
        i_rx_en = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    i_rx_en = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (obs !== expv()) $display("FAIL en_drop: got %h expected %h", obs, expv()); else passed++;
    frame(8'hC3, 1'b0, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL en_recover: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    i_parity_en = 1'b0;
    d = 8'h77;
    frame(8'h42, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    i_rxd = d[3];
    repeat (bitlen / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (obs !== 12'h000) $display("FAIL reset_async: got %h expected %h", obs, 12'h000); else passed++;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    checks++; if (obs !== expv()) $display("FAIL reset_line_low: got %h expected %h", obs, expv()); else passed++;
    i_rxd = 1'b1;
    repeat (50) @(negedge clk);
    frame(d, 1'b0, 1'b1, 1'b0);
    checks++; if (obs !== expv()) $display("FAIL reset_recover_77: got %h expected %h", obs, expv()); else passed++;
    read_byte(1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p, stop;
    for (int n = 0; n < 8; n++) begin
      i_parity_en   = 1'($urandom_range(0, 1));
      i_parity_even = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      p    = (i_parity_even ? ^d : ~^d) ^ 1'($urandom_range(0, 1));
      stop = $urandom_range(0, 3) != 0;
      frame(d, p, stop, 1'b0);
      checks++; if (obs !== expv()) $display("FAIL random_%0d: got %h expected %h", n, obs, expv()); else passed++;
      read_byte(1'b0);
      checks++; if (obs !== expv()) $display("FAIL random_read_%0d: got %h expected %h", n, obs, expv()); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_frame_err();
    test_glitch_fast();
    test_back_to_back();
    test_overrun();
    test_rx_en_drop();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
